// File: rtl/tod_pkg.sv
// tod_pkg: shared mode encoding and field moduli for the time-of-day chain
package tod_pkg;
    typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} tod_mode_e;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HR_MOD  = 24;
endpackage

// File: rtl/tod_set_ctrl_mod_counter.sv
// mod_counter: modulo-N counter with synchronous clear and combinational wrap flag
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over en
//   en         : count enable
//   cnt        : current count, 0..N-1
//   co         : en && cnt == N-1 (the count wraps on this edge)
module mod_counter #(
    parameter int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         co
);
    assign co = en && (cnt == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= co ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/tod_set_ctrl.sv
// tod_set_ctrl: H:M:S time-of-day registers with RUN/SET_HR/SET_MIN mode control
//   clk, rst_n    : clock, asynchronous active-low reset
//   tick          : base enable, PRESCALE ticks per second
//   btn_mode      : pulse, advance mode RUN -> SET_HR -> SET_MIN -> RUN
//   btn_inc       : pulse, increment the field being edited (no carry)
//   sec, min, hr  : time fields
//   mode          : current mode
//   blink         : display-on flag for the edited field
//   co_day        : one-cycle pulse after the 23:59:59 -> 00:00:00 rollover
module tod_set_ctrl
    import tod_pkg::*;
#(
    parameter int PRESCALE  = 10,
    parameter int BLINK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic [1:0] mode,
    output logic       blink,
    output logic       co_day
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    tod_mode_e     mode_q, mode_d;
    logic          run, inc, pre_co, strobe;
    logic          sec_co, min_co, hr_co, min_en, hr_en;
    logic          blink_clr, blink_co;
    logic [PW-1:0] pre_cnt_unused;
    logic [BW-1:0] blink_cnt_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= RUN;
        else
            mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (btn_mode)
            mode_d = (mode_q == RUN) ? SET_HR : (mode_q == SET_HR) ? SET_MIN : RUN;
    end

    assign mode   = mode_q;
    assign run    = (mode_q == RUN);
    // a mode change swallows both the increment and any coincident strobe
    assign inc    = btn_inc & ~btn_mode;
    assign strobe = pre_co & ~btn_mode;
    assign min_en = run ? sec_co : (mode_q == SET_MIN) & inc;
    assign hr_en  = run ? min_co : (mode_q == SET_HR) & inc;

    mod_counter #(.N(PRESCALE)) u_pre (
        .clk(clk), .rst_n(rst_n), .clr(~run | btn_mode), .en(tick & run),
        .cnt(pre_cnt_unused), .co(pre_co)
    );

    mod_counter #(.N(SEC_MOD)) u_sec (
        .clk(clk), .rst_n(rst_n), .clr(run & btn_mode), .en(strobe),
        .cnt(sec), .co(sec_co)
    );

    mod_counter #(.N(MIN_MOD)) u_min (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(min_en),
        .cnt(min), .co(min_co)
    );

    mod_counter #(.N(HR_MOD)) u_hr (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(hr_en),
        .cnt(hr), .co(hr_co)
    );

    // held clear in RUN; mode entry and edits restart the blink period
    assign blink_clr = run | btn_mode | btn_inc;

    mod_counter #(.N(BLINK_DIV)) u_blink (
        .clk(clk), .rst_n(rst_n), .clr(blink_clr), .en(tick),
        .cnt(blink_cnt_unused), .co(blink_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink  <= 1'b1;
            co_day <= 1'b0;
        end else begin
            blink  <= blink_clr ? 1'b1 : blink_co ? ~blink : blink;
            co_day <= run & hr_co;
        end
    end
endmodule

// File: tb/tb_tod_set_ctrl.sv
// tb_tod_set_ctrl: randomized and directed checks of tod_set_ctrl against a seconds-of-day model
module tb_tod_set_ctrl;
    localparam int P = 10;
    localparam int B = 5;

    logic       clk = 1'b0;
    logic       rst_n, tick, btn_mode, btn_inc;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic [1:0] mode;
    logic       blink, co_day;

    int checks = 0;
    int errors = 0;

    int t = 0, mmode = 0, pre = 0, bc = 0;
    bit mbl = 1'b1, mcd = 1'b0;

    tod_set_ctrl #(.PRESCALE(P), .BLINK_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec(sec), .min(min), .hr(hr), .mode(mode), .blink(blink), .co_day(co_day)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // time kept as seconds-of-day; field edits rebuild it from h/m/s
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; mmode = 0; pre = 0; bc = 0; mbl = 1'b1; mcd = 1'b0;
        end else begin
            mcd = 1'b0;
            if (btn_mode) begin
                if (mmode == 0) t = t - t % 60;
                pre = 0; bc = 0; mbl = 1'b1;
                mmode = (mmode + 1) % 3;
            end else if (mmode == 0) begin
                if (tick) begin
                    if (pre == P - 1) begin
                        pre = 0;
                        t = (t + 1) % 86400;
                        mcd = (t == 0);
                    end else pre++;
                end
            end else if (btn_inc) begin
                bc = 0; mbl = 1'b1;
                if (mmode == 1) t = ((t / 3600 + 1) % 24) * 3600 + t % 3600;
                else t = (t / 3600) * 3600 + (((t / 60) % 60 + 1) % 60) * 60 + t % 60;
            end else if (tick) begin
                if (bc == B - 1) begin
                    bc = 0; mbl = ~mbl;
                end else bc++;
            end
        end
    end

    always @(negedge clk) begin
        chk("sec", int'(sec), t % 60);
        chk("min", int'(min), (t / 60) % 60);
        chk("hr", int'(hr), t / 3600);
        chk("mode", int'(mode), mmode);
        chk("blink", int'(blink), int'(mbl));
        chk("co_day", int'(co_day), int'(mcd));
    end

    task automatic step(input logic t_, input logic m_, input logic i_);
        tick = t_; btn_mode = m_; btn_inc = i_;
        @(posedge clk);
        #1;
        tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic lit(input string n, input int h, input int m, input int s);
        chk({n, "_hr"}, int'(hr), h);
        chk({n, "_min"}, int'(min), m);
        chk({n, "_sec"}, int'(sec), s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        lit("reset", 0, 0, 0);
        chk("reset_mode", int'(mode), 0);
        chk("reset_blink", int'(blink), 1);
        chk("reset_co_day", int'(co_day), 0);
        rst_n = 1'b1;

        ticks(10);
        lit("ten_ticks", 0, 0, 1);
        ticks(590);
        lit("six_hundred", 0, 1, 0);

        step(1'b0, 1'b1, 1'b0);
        incs(23);
        step(1'b0, 1'b1, 1'b0);
        incs(58);
        step(1'b0, 1'b1, 1'b0);
        ticks(599);
        lit("pre_wrap", 23, 59, 59);
        chk("pre_wrap_co_day", int'(co_day), 0);
        ticks(1);
        lit("wrap", 0, 0, 0);
        chk("wrap_co_day", int'(co_day), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_co_day_gone", int'(co_day), 0);

        step(1'b0, 1'b1, 1'b0);
        incs(10);
        step(1'b0, 1'b1, 1'b0);
        incs(20);
        step(1'b0, 1'b1, 1'b0);
        ticks(370);
        lit("preset", 10, 20, 37);
        step(1'b0, 1'b1, 1'b0);
        lit("enter_set", 10, 20, 0);
        chk("enter_set_mode", int'(mode), 1);
        ticks(20);
        lit("frozen", 10, 20, 0);
        incs(15);
        lit("hr_wrap", 1, 20, 0);
        step(1'b0, 1'b1, 1'b0);
        incs(45);
        lit("min_wrap", 1, 5, 0);

        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        ticks(4);
        chk("blink_hold", int'(blink), 1);
        ticks(1);
        chk("blink_toggle", int'(blink), 0);
        ticks(3);
        step(1'b0, 1'b0, 1'b1);
        chk("blink_inc_force", int'(blink), 1);
        ticks(4);
        chk("blink_restart_hold", int'(blink), 1);
        ticks(1);
        chk("blink_restart_toggle", int'(blink), 0);

        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("combo_mode", int'(mode), 0);
        lit("combo", 2, 5, 0);
        ticks(9);
        chk("first_strobe_early", int'(sec), 0);
        ticks(1);
        chk("first_strobe", int'(sec), 1);

        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        lit("async_reset", 0, 0, 0);
        chk("async_reset_mode", int'(mode), 0);
        chk("async_reset_blink", int'(blink), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ticks(10);
        lit("after_reset", 0, 0, 1);

        for (int i = 0; i < 3000; i++)
            step(1'($urandom % 2), 1'($urandom % 32 == 0), 1'($urandom % 8 == 0));

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tod_set_ctrl.md
# tod_set_ctrl

Time-of-day controller for the seconds/minutes/hours chain. It owns the H:M:S registers and a mode state machine. In RUN it advances time from a base enable divided by PRESCALE. In SET_HR and SET_MIN, debounced button pulses adjust one field without carry, and a blink flag drives the display. It sits between the button front-end and the display driver.

## Interface
- PRESCALE, default 10: base `tick` pulses per second; must be ≥2.
- BLINK_DIV, default 5: base `tick` pulses per `blink` toggle in set modes; must be ≥1.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  base enable pulse, one clk wide
- btn_mode  in  1  debounced single-cycle pulse: advance mode
- btn_inc  in  1  debounced single-cycle pulse: increment selected field
- sec  out  6  seconds, 0–59
- min  out  6  minutes, 0–59
- hr  out  5  hours, 0–23
- mode  out  2  current mode (RUN=0, SET_HR=1, SET_MIN=2)
- blink  out  1  display-on flag for the field being edited
- co_day  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 rollover

## Operation
- Reset values: sec=0, min=0, hr=0, mode=RUN, blink=1, co_day=0, prescaler=0, blink counter=0.
- States and transitions, all on `btn_mode`:
  - RUN → SET_HR
  - SET_HR → SET_MIN
  - SET_MIN → RUN
  - No other transitions.
- RUN:
  - Prescaler counts `tick` modulo PRESCALE.
  - A seconds strobe fires on the `tick` where the prescaler is PRESCALE-1.
  - On the strobe, sec increments mod 60; carry increments min mod 60; carry increments hr mod 24.
  - `btn_inc` is ignored.
- RUN → SET_HR entry: prescaler and sec clear to 0 in the same edge as the mode change. min and hr hold.
- SET_HR: `btn_inc` increments hr mod 24 (23 → 0). No carry, no effect on min or sec.
- SET_MIN: `btn_inc` increments min mod 60 (59 → 0). No carry into hr.
- Set modes: prescaler is held at 0, so time does not advance.
- SET_MIN → RUN: prescaler resumes from 0. The first seconds strobe occurs on the PRESCALE-th `tick` after exit.
- blink:
  - Constant 1 in RUN.
  - On entry to any set mode: blink=1 and the blink counter is cleared.
  - In set modes, the blink counter counts `tick` mod BLINK_DIV, and `blink` toggles on wrap.
  - Any `btn_inc` forces blink=1 and clears the blink counter, so the field stays visible while being edited.
- co_day: asserted for exactly the cycle after the edge that wraps hr 23→0 through carry in RUN. Never asserted by set-mode increments.
- Simultaneous events:
  - `btn_mode` with `btn_inc`: the mode change wins and the increment is dropped.
  - `btn_mode` with the seconds strobe in RUN: the mode change wins, and the strobe is discarded because sec clears.
- Asynchronous reset mid-operation returns all state to reset values immediately, regardless of mode.

## Timing
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Button response latency: 1 cycle. The pulse sampled at edge N is reflected in outputs after edge N.
- Seconds strobe to counter update: same edge as the qualifying `tick`.
- co_day: high for exactly one clk, on the cycle after the wrap edge.
- `tick`, `btn_mode` and `btn_inc` are sampled only when high at a rising edge. A multi-cycle-high input counts once per cycle; no edge detection is done here.
- Widths: prescaler is $clog2(PRESCALE) bits and the blink counter is $clog2(BLINK_DIV) bits, with a minimum of 1 bit each. Wrap compares use the parameter minus 1, never overflow.

## Structure
- Package `tod_pkg`:
  - `typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} tod_mode_e`
  - Constants SEC_MOD=60, MIN_MOD=60, HR_MOD=24.
- Sub-module `mod_counter #(N)`:
  - Inputs: clk, rst_n, `clr` (synchronous), `en`.
  - Outputs: `cnt` [$clog2(N)-1:0], `co` (combinational, equals en && cnt==N-1).
  - `clr` has priority over `en`.
- Instances:
  - Prescaler: mod_counter #(PRESCALE).
  - Time fields: one instance each for sec, min and hr.
  - Blink counter: mod_counter #(BLINK_DIV).
- Top-level logic: the mode FSM and per-field enable muxing. In RUN the carry chain drives the enables; in set modes `btn_inc` drives them.

## Test plan
- Reset, then RUN with PRESCALE=10:
  - 10 `tick` pulses → sec=1.
  - 600 `tick` pulses from reset → min=1, sec=0.
- Preload 23:59:59 via set modes, then ~59 s of RUN ticks. Next strobe → 00:00:00, co_day high for exactly 1 cycle.
- From 10:20:37 in RUN, `btn_mode` → mode=1, sec=0, time frozen under continued `tick`. Then:
  - 15 `btn_inc` → hr=1 (wrapped).
  - `btn_mode`, then 45 `btn_inc` → min=5, hr unchanged.
- In SET_HR with BLINK_DIV=5, free-running `tick` → blink toggles every 5 ticks. A `btn_inc` mid-period → blink=1, counter restarts.
- `btn_mode` and `btn_inc` in the same cycle while in SET_MIN → mode=RUN, min unchanged. The first strobe lands exactly 10 ticks later.
- Assert rst_n low in SET_MIN between clock edges → all outputs at reset values before the next edge. Deassert → normal RUN counting.
